// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: shared widths and controller state encoding for the data cache
package dcache_ctrl_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} dc_state_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data line storage; comb read at idx, sync write at idx, async valid clear
// Ports: clk, rst_n; idx selects the line; we/wtag/wdata write it; valid/tag/data read it.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);
  logic [LINES-1:0]  v;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else if (we) v[idx] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tags[idx]  <= wtag;
      words[idx] <= wdata;
    end
  assign valid = v[idx];
  assign tag   = tags[idx];
  assign data  = words[idx];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate cache with request/ready memory port
// Ports: addr/wdata/rd_en/wr_en from the memory stage, rdata/stall back to it;
// mem_addr/mem_wdata/mem_re/mem_we/mem_rdata/mem_rdy to main memory.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  dc_state_t state, next;
  logic line_valid, hit, arr_we, stall_c;
  logic [TAG_W-1:0] line_tag;
  logic [DATA_W-1:0] line_data, arr_data;
  dcache_array #(.LINES(LINES)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (addr[IDX_W-1:0]),
    .we    (arr_we),
    .wtag  (addr[ADDR_W-1:IDX_W]),
    .wdata (arr_data),
    .valid (line_valid),
    .tag   (line_tag),
    .data  (line_data)
  );
  assign hit = line_valid && line_tag == addr[ADDR_W-1:IDX_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next     = state;
    stall_c  = 1'b0;
    rdata    = '0;
    arr_we   = 1'b0;
    arr_data = wdata;
    case (state)
      IDLE:
        if (wr_en) begin
          stall_c = 1'b1;
          arr_we  = hit;
          next    = WR_WAIT;
        end else if (rd_en) begin
          stall_c = !hit;
          rdata   = hit ? line_data : '0;
          next    = hit ? IDLE : RD_WAIT;
        end
      RD_WAIT: begin
        stall_c  = !mem_rdy;
        rdata    = mem_rdy ? mem_rdata : '0;
        arr_we   = mem_rdy;
        arr_data = mem_rdata;
        next     = mem_rdy ? IDLE : RD_WAIT;
      end
      WR_WAIT: begin
        stall_c = !mem_rdy;
        next    = mem_rdy ? IDLE : WR_WAIT;
      end
      default: next = IDLE;
    endcase
  end
  // Stall is forced low while reset is held so the pipeline is never frozen by a miss that reset cancelled.
  assign stall     = rst_n && stall_c;
  assign mem_re    = state == RD_WAIT;
  assign mem_we    = state == WR_WAIT;
  assign mem_addr  = state != IDLE ? addr : '0;
  assign mem_wdata = state == WR_WAIT ? wdata : '0;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic rd_en = 1'b0, wr_en = 1'b0, mem_rdy = 1'b0;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic stall, mem_re, mem_we;
  int checks = 0, errors = 0;
  int st;
  logic [15:0] rd, ma, mw;
  bit sre, swe;

  dcache_ctrl #(.LINES(16)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rd_en(rd_en), .wr_en(wr_en),
    .rdata(rdata), .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One access: memory answers with md in the L-th cycle its request is seen high.
  task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] md, input int lat, output int stalls,
                        output logic [15:0] rdo, output bit saw_re, output bit saw_we,
                        output logic [15:0] maddr, output logic [15:0] mwd);
    int n;
    bit done;
    n = 0; done = 0; stalls = 0; saw_re = 0; saw_we = 0; rdo = 'x; maddr = '0; mwd = '0;
    @(posedge clk); #1;
    rd_en = r; wr_en = w; addr = a; wdata = d; mem_rdata = md; mem_rdy = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (mem_re || mem_we) begin
        n++;
        saw_re |= mem_re; saw_we |= mem_we; maddr = mem_addr; mwd = mem_wdata;
      end
      mem_rdy = (n == lat);
      @(negedge clk);
      if (!stall) begin
        rdo = rdata;
        done = 1;
      end else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL access_timeout: addr %h still stalled after 50 cycles, expected completion", a);
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0; mem_rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_mem_re", {15'd0, mem_re}, 16'd0);
    chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
    chk("rst_rdata", rdata, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'd0);
    chk("rst_mem_wdata", mem_wdata, 16'd0);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_read_miss_hit;
    access(1, 0, 16'h0012, 0, 16'hBEEF, 3, st, rd, sre, swe, ma, mw);
    chk("miss_stalls", 16'(st), 16'd3);
    chk("miss_rdata", rd, 16'hBEEF);
    chk("miss_mem_re", {15'd0, sre}, 16'd1);
    chk("miss_mem_addr", ma, 16'h0012);
    access(1, 0, 16'h0012, 0, 16'h0000, 3, st, rd, sre, swe, ma, mw);
    chk("hit_stalls", 16'(st), 16'd0);
    chk("hit_rdata", rd, 16'hBEEF);
    chk("hit_no_mem_re", {15'd0, sre}, 16'd0);
  endtask

  task automatic test_write_hit;
    access(0, 1, 16'h0012, 16'h1234, 0, 2, st, rd, sre, swe, ma, mw);
    chk("wh_stalls", 16'(st), 16'd2);
    chk("wh_mem_we", {15'd0, swe}, 16'd1);
    chk("wh_no_mem_re", {15'd0, sre}, 16'd0);
    chk("wh_mem_addr", ma, 16'h0012);
    chk("wh_mem_wdata", mw, 16'h1234);
    access(1, 0, 16'h0012, 0, 16'h0000, 2, st, rd, sre, swe, ma, mw);
    chk("wh_reload_stalls", 16'(st), 16'd0);
    chk("wh_reload_rdata", rd, 16'h1234);
  endtask

  task automatic test_write_miss;
    access(0, 1, 16'h0040, 16'h5555, 0, 1, st, rd, sre, swe, ma, mw);
    chk("wm_stalls", 16'(st), 16'd1);
    chk("wm_mem_wdata", mw, 16'h5555);
    access(1, 0, 16'h0040, 0, 16'h5555, 2, st, rd, sre, swe, ma, mw);
    chk("wm_load_mem_re", {15'd0, sre}, 16'd1);
    chk("wm_load_stalls", 16'(st), 16'd2);
    chk("wm_load_rdata", rd, 16'h5555);
  endtask

  task automatic test_alias;
    access(1, 0, 16'h0003, 0, 16'hAAAA, 1, st, rd, sre, swe, ma, mw);
    chk("al_first_rdata", rd, 16'hAAAA);
    access(1, 0, 16'h0013, 0, 16'hBBBB, 1, st, rd, sre, swe, ma, mw);
    chk("al_second_mem_re", {15'd0, sre}, 16'd1);
    chk("al_second_rdata", rd, 16'hBBBB);
    access(1, 0, 16'h0003, 0, 16'hCCCC, 1, st, rd, sre, swe, ma, mw);
    chk("al_evicted_mem_re", {15'd0, sre}, 16'd1);
    chk("al_evicted_stalls", 16'(st), 16'd1);
    chk("al_evicted_rdata", rd, 16'hCCCC);
  endtask

  task automatic test_both_strobes;
    access(1, 1, 16'h0007, 16'h0A0A, 16'hDEAD, 2, st, rd, sre, swe, ma, mw);
    chk("both_mem_we", {15'd0, swe}, 16'd1);
    chk("both_no_mem_re", {15'd0, sre}, 16'd0);
    chk("both_stalls", 16'(st), 16'd2);
    chk("both_mem_wdata", mw, 16'h0A0A);
  endtask

  task automatic test_idle_rdy;
    @(posedge clk); #1;
    mem_rdy = 1'b1;
    @(negedge clk);
    chk("idle_stall", {15'd0, stall}, 16'd0);
    chk("idle_rdata", rdata, 16'd0);
    @(posedge clk); #1;
    mem_rdy = 1'b0;
    chk("idle_rdy_mem_re", {15'd0, mem_re}, 16'd0);
    chk("idle_rdy_mem_addr", mem_addr, 16'd0);
  endtask

  task automatic test_reset_mid_miss;
    @(posedge clk); #1;
    rd_en = 1'b1; addr = 16'h0021;
    @(posedge clk); #1;
    chk("rm_mem_re_before", {15'd0, mem_re}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_mem_re_async", {15'd0, mem_re}, 16'd0);
    chk("rm_stall_async", {15'd0, stall}, 16'd0);
    mem_rdy = 1'b1;
    @(posedge clk); #1;
    mem_rdy = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rdy = 1'b1;
    @(posedge clk); #1;
    mem_rdy = 1'b0;
    access(1, 0, 16'h0021, 0, 16'h7777, 2, st, rd, sre, swe, ma, mw);
    chk("rm_reload_mem_re", {15'd0, sre}, 16'd1);
    chk("rm_reload_stalls", 16'(st), 16'd2);
    chk("rm_reload_rdata", rd, 16'h7777);
  endtask

  initial begin
    test_reset;
    test_read_miss_hit;
    test_write_hit;
    test_write_miss;
    test_alias;
    test_both_strobes;
    test_idle_rdy;
    test_reset_mid_miss;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
